// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_drain
// Purpose  : Snapshots the PE-array result bus a fixed latency after start and
//            streams it out element by element on a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module systolic_result_drain #(
    parameter int M        = 5,
    parameter int X        = 4,
    parameter int Y        = 4,
    parameter int L2       = 9,
    parameter int WAIT_CYC = L2 + X + Y
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [X*Y*M-1:0]                     Data,
    output logic [M-1:0]                         out_data,
    output logic [((X > 1) ? $clog2(X) : 1)-1:0] out_row,
    output logic [((Y > 1) ? $clog2(Y) : 1)-1:0] out_col,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int C_RW = (X > 1) ? $clog2(X) : 1;
    localparam int C_CW = (Y > 1) ? $clog2(Y) : 1;
    localparam int C_TW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;
    localparam int C_BW = (X * Y * M > 1) ? $clog2(X * Y * M) : 1;

    localparam logic [C_RW-1:0] C_ROW_LAST = C_RW'(X - 1);
    localparam logic [C_CW-1:0] C_COL_LAST = C_CW'(Y - 1);
    localparam logic [C_TW-1:0] C_CNT_LAST = C_TW'(WAIT_CYC);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_WAIT   = 2'd1;
    localparam logic [1:0] C_ST_STREAM = 2'd2;

    logic [1:0]       r_state;
    logic [C_TW-1:0]  r_cnt;
    logic [C_RW-1:0]  r_row;
    logic [C_CW-1:0]  r_col;
    logic [X*Y*M-1:0] r_snap;
    logic [M-1:0]     r_data;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [C_TW-1:0]  w_cnt_nxt;
    logic [C_RW-1:0]  w_row_nxt;
    logic [C_CW-1:0]  w_col_nxt;
    logic [X*Y*M-1:0] w_snap_nxt;
    logic [M-1:0]     w_data_nxt;
    logic             w_done_nxt;

    logic             w_col_wrap;
    logic             w_last;
    logic [C_RW-1:0]  w_row_adv;
    logic [C_CW-1:0]  w_col_adv;
    logic [C_BW-1:0]  w_base;

    // Row-major walk: column runs fastest, row steps when the column wraps.
    assign w_col_wrap = (r_col == C_COL_LAST);
    assign w_last     = w_col_wrap && (r_row == C_ROW_LAST);
    assign w_col_adv  = w_col_wrap ? '0 : r_col + 1'b1;
    assign w_row_adv  = w_col_wrap ? r_row + 1'b1 : r_row;
    assign w_base     = (C_BW'(w_row_adv) * C_BW'(Y) + C_BW'(w_col_adv)) * C_BW'(M);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_snap_nxt  = r_snap;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;

        case (r_state)
            C_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = C_ST_WAIT;
                    w_cnt_nxt   = C_TW'(1);
                end
            end

            C_ST_WAIT: begin
                if (r_cnt == C_CNT_LAST) begin
                    // The snapshot is not written yet, so element (0,0) comes straight off the bus.
                    w_state_nxt = C_ST_STREAM;
                    w_cnt_nxt   = '0;
                    w_snap_nxt  = Data;
                    w_data_nxt  = Data[M-1:0];
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            C_ST_STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = C_ST_IDLE;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_row_nxt  = w_row_adv;
                        w_col_nxt  = w_col_adv;
                        w_data_nxt = r_snap[w_base +: M];
                    end
                end
            end

            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_snap  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_snap  <= w_snap_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_valid = (r_state == C_ST_STREAM);
    assign busy      = (r_state != C_ST_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_result_drain
// Purpose  : Directed self-checking bench for systolic_result_drain.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_result_drain;

    localparam int M        = 5;
    localparam int X        = 4;
    localparam int Y        = 4;
    localparam int L2       = 9;
    localparam int WAIT_CYC = L2 + X + Y;
    localparam int NE       = X * Y;
    localparam int RW       = 2;
    localparam int CW       = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             out_ready;
    logic [NE*M-1:0]  data_bus;
    logic [M-1:0]     out_data;
    logic [RW-1:0]    out_row;
    logic [CW-1:0]    out_col;
    logic             out_valid;
    logic             busy;
    logic             done;

    systolic_result_drain #(
        .M(M), .X(X), .Y(Y), .L2(L2), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Data      (data_bus),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [M-1:0]  data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } elem_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: queue of pending elements filled at capture time.
    elem_t        m_q[$];
    logic         m_active = 1'b0;
    int           m_cap    = 0;
    logic [M-1:0] m_last   = '0;
    logic         m_done   = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_last   = '0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active && m_q.size() != 0) begin
                if (out_ready) begin
                    elem_t e;
                    e = m_q.pop_front();
                    if (m_q.size() == 0) begin
                        m_last   = e.data;
                        m_done   = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end else if (m_active) begin
                if (cyc == m_cap)
                    for (int i = 0; i < NE; i++)
                        m_q.push_back('{data: data_bus[i*M +: M], row: RW'(i / Y), col: CW'(i % Y)});
            end else if (start) begin
                m_active = 1'b1;
                m_cap    = cyc + WAIT_CYC;
            end
        end
        cyc++;
    end

    // Compare process plus handshake monitor, sampled on the falling edge.
    logic  chk_en      = 1'b0;
    logic  h_prev      = 1'b0;
    elem_t prev_e;
    elem_t exp_e;
    int    first_valid = -1;
    int    done_cnt    = 0;
    elem_t rx[$];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (m_q.size() != 0) exp_e = m_q[0];
            else                 exp_e = '{data: m_last, row: '0, col: '0};
            check("out_valid", out_valid, (m_q.size() != 0) ? 1 : 0);
            check("busy",      busy,      m_active);
            check("done",      done,      m_done);
            check("out_data",  out_data,  exp_e.data);
            check("out_row",   out_row,   exp_e.row);
            check("out_col",   out_col,   exp_e.col);
            if (h_prev) begin
                check("hold_data", out_data, prev_e.data);
                check("hold_row",  out_row,  prev_e.row);
                check("hold_col",  out_col,  prev_e.col);
            end
        end
        h_prev = out_valid && !out_ready && !rst;
        prev_e = '{data: out_data, row: out_row, col: out_col};
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (done) done_cnt++;
        if (out_valid && out_ready) rx.push_back('{data: out_data, row: out_row, col: out_col});
    end

    int t_start = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < NE; i++) data_bus[i*M +: M] = M'(i + 1);
    endtask

    task automatic start_now();
        start       = 1'b1;
        t_start     = cyc;
        first_valid = -1;
        rx.delete();
    endtask

    task automatic start_pulse();
        tick();
        start_now();
    endtask

    // Drives one drain to its done cycle; returns with the bench sitting in that cycle.
    task automatic run_drain(input bit bp, input int extra_a, input int extra_b,
                             input int swap_at, output int done_rel);
        bit got;
        int rel;
        got      = 1'b0;
        done_rel = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            rel       = cyc - t_start;
            start     = (rel == extra_a) || (rel == extra_b);
            out_ready = bp ? ((k % 3) == 0) : 1'b1;
            if (rel == swap_at) data_bus = '1;
            if (done) begin
                got      = 1'b1;
                done_rel = rel;
                break;
            end
        end
        check("drain_completes", got, 1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, rx.size(), 16);
        for (int i = 0; i < NE && i < rx.size(); i++) begin
            check({tag, "_data"}, rx[i].data, i + 1);
            check({tag, "_row"},  rx[i].row,  i / 4);
            check({tag, "_col"},  rx[i].col,  i % 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drel;
        int base;
        bit hit;

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        load_pattern();
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_out_data",  out_data,  0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic drain with out_ready held high
        base = done_cnt;
        start_pulse();
        run_drain(1'b0, -1, -1, -1, drel);
        check("basic_first_valid", first_valid - t_start, 18);
        check("basic_done_at",     drel, 34);
        check_stream("basic");
        repeat (3) tick();
        check("basic_done_pulses", done_cnt - base, 1);

        // Backpressure 1,0,0 repeating
        base = done_cnt;
        start_pulse();
        run_drain(1'b1, -1, -1, -1, drel);
        check_stream("bp");
        repeat (3) tick();
        check("bp_done_pulses", done_cnt - base, 1);

        // Bus goes all-ones one cycle after the capture cycle
        start_pulse();
        run_drain(1'b0, -1, -1, 18, drel);
        check_stream("iso");
        check("iso_done_at", drel, 34);
        load_pattern();
        repeat (2) tick();

        // Extra start pulses during WAIT and STREAM are ignored
        base = done_cnt;
        start_pulse();
        run_drain(1'b0, 5, 22, -1, drel);
        check("ign_first_valid", first_valid - t_start, 18);
        check("ign_done_at",     drel, 34);
        check_stream("ign");
        repeat (20) tick();
        check("ign_done_pulses", done_cnt - base, 1);

        // Restart in the done cycle
        start_pulse();
        run_drain(1'b0, -1, -1, -1, drel);
        start_now();
        run_drain(1'b0, -1, -1, -1, drel);
        check("rs_first_valid", first_valid - t_start, 18);
        check("rs_done_at",     drel, 34);
        check_stream("rs");
        repeat (2) tick();

        // Reset while element 5 is presented
        start_pulse();
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start     = 1'b0;
            out_ready = 1'b1;
            if (out_valid && out_data == 5) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_reached_elem5", hit, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_out_valid", out_valid, 0);
        check("mid_out_data",  out_data,  0);
        check("mid_out_row",   out_row,   0);
        check("mid_out_col",   out_col,   0);
        check("mid_busy",      busy,      0);
        check("mid_done",      done,      0);
        start_pulse();
        run_drain(1'b0, -1, -1, -1, drel);
        check("mid_first_valid", first_valid - t_start, 18);
        check("mid_done_at",     drel, 34);
        check_stream("mid");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
